// File: rtl/serlink_master.sv
// Serial link master: sends NCMD framed words, then gathers framed replies
// until a frame with the exec flag arrives or the reply window times out.
module serlink_master #(
    parameter int NBITS   = 8,
    parameter int NCMD    = 5,
    parameter int NRSP    = 5,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [NCMD*NBITS-1:0] cmd_data,
    output logic                  serout,
    input  logic                  serin,
    output logic                  rsp_valid,
    output logic [NRSP*NBITS-1:0] rsp_data,
    output logic [7:0]            rsp_len,
    output logic [1:0]            rsp_status,
    output logic                  busy,
    output logic [15:0]           bytes_sent,
    output logic [15:0]           bytes_seen,
    output logic [15:0]           stray_count,
    output logic [15:0]           frame_err
);
    localparam int F  = 2 + NBITS + GAP;
    localparam int CW = NCMD * NBITS;
    localparam int RW = NRSP * NBITS;
    localparam int BW = $clog2(F + 1);
    localparam int FW = $clog2(NCMD + 1);
    localparam int XW = $clog2(NBITS + GAP + 1);
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    tx_sh, tx_sh_nxt;
    logic [BW-1:0]    bcnt, bcnt_nxt;
    logic [FW-1:0]    fcnt, fcnt_nxt;
    logic [NBITS-1:0] tx_pay;
    logic             tx_bit;
    logic             accept;
    logic             tx_last;
    logic             tx_step;
    logic             tx_sof;

    logic             serin_q;
    logic             rx_busy;
    logic             rx_exec;
    logic             rx_gerr;
    logic [XW-1:0]    rx_cnt;
    logic [NBITS-1:0] rx_sh;
    logic [NBITS-1:0] rx_pay;
    logic             rx_done;
    logic             rx_gap_end;
    logic             rx_bad;

    logic [15:0]      tcnt;
    logic [7:0]       len_nxt;
    logic [RW-1:0]    rsp_shift;

    // Transmit sequencing: compute the bit that goes out on the next edge.
    always_comb begin
        accept    = (state == IDLE) && cmd_valid;
        tx_last   = (bcnt == BW'(F - 1)) && (fcnt == FW'(NCMD - 1));
        tx_step   = accept || ((state == SEND) && !tx_last);
        tx_sh_nxt = tx_sh;
        bcnt_nxt  = bcnt;
        fcnt_nxt  = fcnt;
        if (accept) begin
            tx_sh_nxt = cmd_data;
            bcnt_nxt  = '0;
            fcnt_nxt  = '0;
        end else if (bcnt == BW'(F - 1)) begin
            tx_sh_nxt = tx_sh << NBITS;
            bcnt_nxt  = '0;
            fcnt_nxt  = fcnt + FW'(1);
        end else begin
            bcnt_nxt  = bcnt + BW'(1);
        end
        tx_sof = (bcnt_nxt == '0);
        tx_pay = tx_sh_nxt[CW-1 -: NBITS] << (bcnt_nxt - BW'(2));
        tx_bit = 1'b0;
        if (tx_sof) begin
            tx_bit = 1'b1;
        end else if (bcnt_nxt == BW'(1)) begin
            tx_bit = (fcnt_nxt == FW'(NCMD - 1));
        end else if (bcnt_nxt <= BW'(NBITS + 1)) begin
            tx_bit = tx_pay[NBITS-1];
        end
    end

    always_comb begin
        rx_pay     = NBITS'({rx_sh, serin_q});
        rx_done    = rx_busy && (rx_cnt == XW'(NBITS));
        rx_gap_end = rx_busy && (rx_cnt == XW'(NBITS + GAP));
        rx_bad     = rx_gerr || (serin_q && (rx_cnt > XW'(NBITS)));
        len_nxt    = (rsp_len == 8'hFF) ? rsp_len : rsp_len + 8'd1;
        rsp_shift  = RW'({rsp_data, rx_pay});
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        unique case (state)
            IDLE:     if (cmd_valid) state_nxt = SEND;
            SEND:     if (tx_last) state_nxt = WAIT_RSP;
            WAIT_RSP: begin
                if (rx_done) begin
                    if (rx_exec) state_nxt = IDLE;
                end else if (tcnt == TLAST) begin
                    state_nxt = IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh      <= '0;
            bcnt       <= '0;
            fcnt       <= '0;
            serout     <= 1'b0;
            bytes_sent <= '0;
        end else begin
            if (tx_step) begin
                tx_sh  <= tx_sh_nxt;
                bcnt   <= bcnt_nxt;
                fcnt   <= fcnt_nxt;
                serout <= tx_bit;
                if (tx_sof) bytes_sent <= bytes_sent + 16'd1;
            end else begin
                serout <= 1'b0;
            end
        end
    end

    // Receiver runs in every state; the FSM only decides what a frame means.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            serin_q     <= 1'b0;
            rx_busy     <= 1'b0;
            rx_exec     <= 1'b0;
            rx_gerr     <= 1'b0;
            rx_cnt      <= '0;
            rx_sh       <= '0;
            bytes_seen  <= '0;
            stray_count <= '0;
            frame_err   <= '0;
        end else begin
            serin_q <= serin;
            if (!rx_busy) begin
                if (serin_q) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_gerr <= 1'b0;
                end
            end else begin
                rx_cnt <= rx_cnt + XW'(1);
                if (rx_cnt == '0) begin
                    rx_exec <= serin_q;
                end else if (rx_cnt <= XW'(NBITS)) begin
                    rx_sh <= rx_pay;
                end else if (serin_q) begin
                    rx_gerr <= 1'b1;
                end
                if (rx_gap_end) begin
                    rx_busy <= 1'b0;
                    if (rx_bad) frame_err <= frame_err + 16'd1;
                end
            end
            if (rx_done) begin
                bytes_seen <= bytes_seen + 16'd1;
                if (state != WAIT_RSP) stray_count <= stray_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt       <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_len    <= '0;
            rsp_status <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                tcnt       <= '0;
                rsp_data   <= '0;
                rsp_len    <= '0;
                rsp_status <= '0;
            end
            // A frame landing on the timeout cycle wins over the timeout.
            if (state == WAIT_RSP) begin
                if (rx_done) begin
                    tcnt     <= '0;
                    rsp_data <= rsp_shift;
                    rsp_len  <= len_nxt;
                    if (rx_exec) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= {(len_nxt > 8'(NRSP)), 1'b0};
                    end
                end else if (tcnt == TLAST) begin
                    rsp_valid  <= 1'b1;
                    rsp_status <= 2'b01;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serlink_master.sv
// Directed bench for serlink_master: framing, replies, timeout, overflow,
// stray and gap-error handling, and reset in the middle of a send.
module tb_serlink_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [39:0] cmd_data = '0;
    logic        serout;
    logic        serin = 1'b0;
    logic        rsp_valid;
    logic [39:0] rsp_data;
    logic [7:0]  rsp_len;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [15:0] bytes_sent;
    logic [15:0] bytes_seen;
    logic [15:0] stray_count;
    logic [15:0] frame_err;

    int checks = 0;
    int errors = 0;

    logic rbits [0:1023];
    int   rlen = 0;

    serlink_master #(
        .NBITS(8), .NCMD(5), .NRSP(5), .GAP(2), .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .serout(serout), .serin(serin),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_len(rsp_len),
        .rsp_status(rsp_status), .busy(busy),
        .bytes_sent(bytes_sent), .bytes_seen(bytes_seen),
        .stray_count(stray_count), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_frame(input logic ex, input logic [7:0] b,
                             input logic [1:0] gp);
        rbits[rlen]      = 1'b1;
        rbits[rlen + 1]  = ex;
        for (int i = 0; i < 8; i++) rbits[rlen + 2 + i] = b[7 - i];
        rbits[rlen + 10] = gp[1];
        rbits[rlen + 11] = gp[0];
        rlen += 12;
    endtask

    function automatic logic [59:0] exp_stream(input logic [39:0] d);
        logic [59:0] s;
        logic [7:0]  b;
        s = '0;
        for (int i = 0; i < 5; i++) begin
            b = d[39 - 8 * i -: 8];
            s = {s[47:0], 1'b1, (i == 4), b, 2'b00};
        end
        return s;
    endfunction

    task automatic send_cmd(input logic [39:0] d, output logic [59:0] s,
                            output int rdy_lo);
        cmd_data  = d;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        s = '0;
        rdy_lo = 0;
        for (int k = 0; k < 60; k++) begin
            s = {s[58:0], serout};
            if (!cmd_ready) rdy_lo++;
            step();
        end
    endtask

    // Plays the reply vector starting roff cycles in, watching rsp_valid.
    task automatic run_wait(input int roff, input int win,
                            output int first, output int pulses);
        first = -1;
        pulses = 0;
        for (int n = 0; n < win; n++) begin
            serin = (n >= roff && n < roff + rlen) ? rbits[n - roff] : 1'b0;
            if (rsp_valid) begin
                pulses++;
                if (first < 0) first = n;
            end
            step();
        end
        serin = 1'b0;
    endtask

    logic [59:0] s;
    int          rdy_lo;
    int          first;
    int          pulses;

    initial begin
        step();
        step();
        chk("reset_serout", 64'(serout), 64'd0);
        rst_n = 1'b1;
        step();
        chk("reset_ready", 64'(cmd_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_cnts", {bytes_sent, bytes_seen, stray_count, frame_err}, 64'd0);
        chk("reset_rsp", {14'd0, rsp_status, rsp_len, rsp_data}, 64'd0);

        // Reset in the middle of SEND while the start bit is on the line.
        cmd_data  = 40'hFF_FFFF_FFFF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("midsend_start", 64'(serout), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midsend_async_serout", 64'(serout), 64'd0);
        chk("midsend_async_busy", 64'(busy), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        chk("abort_cnts", {bytes_sent, bytes_seen, stray_count, frame_err}, 64'd0);
        rlen = 0;
        run_wait(0, 200, first, pulses);
        chk("abort_no_valid", 64'(pulses), 64'd0);

        // Framing plus a normal three-frame reply.
        send_cmd(40'h12_3456_789A, s, rdy_lo);
        chk("tx_frame0", 64'(s[59:48]), 64'b1_0_00010010_00);
        chk("tx_frame4", 64'(s[11:0]), 64'b1_1_10011010_00);
        chk("tx_stream", 64'(s), 64'(exp_stream(40'h12_3456_789A)));
        chk("tx_ready_low", 64'(rdy_lo), 64'd60);
        chk("tx_bytes_sent", 64'(bytes_sent), 64'd5);
        chk("tx_wait_busy", {63'd0, busy}, 64'd1);
        rlen = 0;
        add_frame(1'b0, 8'hAB, 2'b00);
        add_frame(1'b0, 8'hCD, 2'b00);
        add_frame(1'b1, 8'hEF, 2'b00);
        run_wait(0, 220, first, pulses);
        chk("norm_pulses", 64'(pulses), 64'd1);
        chk("norm_data", 64'(rsp_data), 64'h00_00AB_CDEF);
        chk("norm_len", 64'(rsp_len), 64'd3);
        chk("norm_status", 64'(rsp_status), 64'd0);
        chk("norm_seen", 64'(bytes_seen), 64'd3);
        chk("norm_idle", 64'(cmd_ready), 64'd1);

        // No reply: timeout fires 100 cycles after entering WAIT_RSP.
        send_cmd(40'hA5_0000_005A, s, rdy_lo);
        chk("to_stream", 64'(s), 64'(exp_stream(40'hA5_0000_005A)));
        rlen = 0;
        run_wait(0, 220, first, pulses);
        chk("to_when", 64'(first), 64'd100);
        chk("to_pulses", 64'(pulses), 64'd1);
        chk("to_status", 64'(rsp_status), 64'd1);
        chk("to_len", 64'(rsp_len), 64'd0);
        chk("to_sent", 64'(bytes_sent), 64'd10);

        // A frame completing 71 cycles in restarts the timeout window.
        send_cmd(40'h01_0203_0405, s, rdy_lo);
        rlen = 0;
        add_frame(1'b0, 8'h11, 2'b00);
        run_wait(60, 220, first, pulses);
        chk("tor_when", 64'(first), 64'd171);
        chk("tor_status", 64'(rsp_status), 64'd1);
        chk("tor_len", 64'(rsp_len), 64'd1);
        chk("tor_data", 64'(rsp_data), 64'h11);
        chk("tor_seen", 64'(bytes_seen), 64'd4);

        // Seven frames overflow the five-frame response window.
        send_cmd(40'h00_0000_0000, s, rdy_lo);
        rlen = 0;
        for (int i = 1; i <= 7; i++) add_frame(i == 7, 8'(i), 2'b00);
        run_wait(3, 220, first, pulses);
        chk("ovf_pulses", 64'(pulses), 64'd1);
        chk("ovf_data", 64'(rsp_data), 64'h03_0405_0607);
        chk("ovf_len", 64'(rsp_len), 64'd7);
        chk("ovf_status", 64'(rsp_status), 64'd2);
        chk("ovf_seen", 64'(bytes_seen), 64'd11);

        // A 1 in the first gap bit is counted but the payload is kept.
        send_cmd(40'hC3_C3C3_C3C3, s, rdy_lo);
        rlen = 0;
        add_frame(1'b1, 8'h5A, 2'b10);
        run_wait(0, 60, first, pulses);
        chk("ferr_cnt", 64'(frame_err), 64'd1);
        chk("ferr_data", 64'(rsp_data), 64'h5A);
        chk("ferr_len", 64'(rsp_len), 64'd1);
        chk("ferr_status", 64'(rsp_status), 64'd0);
        chk("ferr_pulses", 64'(pulses), 64'd1);

        // A frame arriving in IDLE is only counted as stray.
        rlen = 0;
        add_frame(1'b1, 8'h77, 2'b00);
        run_wait(5, 60, first, pulses);
        chk("stray_cnt", 64'(stray_count), 64'd1);
        chk("stray_pulses", 64'(pulses), 64'd0);
        chk("stray_seen", 64'(bytes_seen), 64'd13);
        chk("stray_hold", 64'(rsp_data), 64'h5A);
        chk("stray_sent", 64'(bytes_sent), 64'd25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
